// File: rtl/llc_pkg.sv
// llc_pkg: shared LLC address-partition constants, line coordinate type and address composition.
package llc_pkg;
  localparam int ADDR_W = 32;
  localparam int TAG_W = 12;
  localparam int INDEX_W = 14;
  localparam int OFFSET_W = 6;
  localparam int LINE_BYTES = 64;
  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
  } llc_line_t;
  typedef enum logic {IDLE, BURST} wb_state_e;
  function automatic logic [ADDR_W-1:0] compose_line_addr(llc_line_t l);
    return {l.tag, l.index, {OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/llc_writeback_issuer_if.sv
// llc_writeback_issuer_if: eviction-request input and write-burst output handshakes.
interface llc_writeback_issuer_if import llc_pkg::*; #(
    parameter int DEPTH      = 4,
    parameter int BEAT_BYTES = 8
);
    localparam int BEATS  = LINE_BYTES / BEAT_BYTES;
    localparam int BEAT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    logic               in_valid;
    logic               in_ready;
    logic [TAG_W-1:0]   in_tag;
    logic [INDEX_W-1:0] in_index;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_addr;
    logic [BEAT_W-1:0]  out_beat;
    logic               out_last;
    logic [CNT_W-1:0]   count;
    modport master (output in_valid, in_tag, in_index, out_ready,
                    input in_ready, out_valid, out_addr, out_beat, out_last, count);
    modport slave  (input in_valid, in_tag, in_index, out_ready,
                    output in_ready, out_valid, out_addr, out_beat, out_last, count);
endinterface

// File: rtl/llc_writeback_issuer_wb_fifo.sv
// wb_fifo: synchronous FIFO of victim line coordinates with occupancy count.
module wb_fifo import llc_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  llc_line_t                    wdata_i,
    input  logic                         pop_i,
    output llc_line_t                    rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    llc_line_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    always_comb cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end
    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end
    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/llc_writeback_issuer.sv
// llc_writeback_issuer: buffers evicted dirty lines and issues each as a multi-beat write burst.
module llc_writeback_issuer import llc_pkg::*; #(
    parameter int DEPTH      = 4,
    parameter int BEAT_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    llc_writeback_issuer_if.slave  bus
);
    localparam int BEATS  = LINE_BYTES / BEAT_BYTES;
    localparam int BEAT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int SH     = $clog2(BEAT_BYTES);
    logic              full, empty, push, pop, last;
    llc_line_t         wdata, head;
    wb_state_e         state;
    logic [BEAT_W-1:0] beat_q, beat_d;
    // Burst state is implied by occupancy rather than held in its own register.
    assign state = empty ? IDLE : BURST;
    assign last  = beat_q == BEAT_W'(BEATS - 1);
    assign push  = bus.in_valid && !full;
    assign pop   = state == BURST && bus.out_ready && last;
    assign wdata = '{tag: bus.in_tag, index: bus.in_index};
    always_comb beat_d = (state == BURST && bus.out_ready) ? (last ? '0 : beat_q + 1'b1) : beat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) beat_q <= '0;
        else beat_q <= beat_d;
    end
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (bus.count),
        .full_o  (full),
        .empty_o (empty)
    );
    assign bus.in_ready  = !full;
    assign bus.out_valid = state == BURST;
    assign bus.out_beat  = beat_q;
    assign bus.out_last  = last;
    // Beat offset stays below the line size, so OR-ing it in never carries into the index.
    assign bus.out_addr  = state == BURST
                         ? compose_line_addr(head) | ADDR_W'(OFFSET_W'(beat_q) << SH) : '0;
endmodule

// File: tb/tb_llc_writeback_issuer.sv
// tb_llc_writeback_issuer: directed self-checking bench for the writeback burst issuer.
module tb_llc_writeback_issuer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    llc_writeback_issuer_if #(.DEPTH(4), .BEAT_BYTES(8)) bus();
    llc_writeback_issuer #(.DEPTH(4), .BEAT_BYTES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [11:0] t, input logic [13:0] x);
        return {t, x, 6'b0};
    endfunction

    task automatic push(input logic [11:0] t, input logic [13:0] x);
        bus.in_valid = 1'b1;
        bus.in_tag   = t;
        bus.in_index = x;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Expects out_ready=1 held; checks n consecutive beats starting at beat 0.
    task automatic burst(input string tag, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_addr"}, bus.out_addr, base + 32'(8 * i));
            chk({tag, "_beat"}, 32'(bus.out_beat), 32'(i));
            chk({tag, "_last"}, 32'(bus.out_last), 32'(i == 7));
            @(negedge clk);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_addr"}, bus.out_addr, 32'd0);
        chk({tag, "_beat"}, 32'(bus.out_beat), 32'd0);
        chk({tag, "_last"}, 32'(bus.out_last), 32'd0);
    endtask

    initial begin
        int eb;
        bus.in_valid = 1'b0;
        bus.in_tag = '0;
        bus.in_index = '0;
        bus.out_ready = 1'b0;
        #12;
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("idle");

        // single entry, continuous out_ready
        bus.out_ready = 1'b1;
        push(12'hABC, 14'h1234);
        chk("single_count", 32'(bus.count), 32'd1);
        chk("single_base", bus.out_addr, 32'hABC48D00);
        burst("single", 32'hABC48D00, 8);
        chk("single_done_count", 32'(bus.count), 32'd0);
        chk("single_done_valid", 32'(bus.out_valid), 32'd0);

        // maximum coordinates: no carry out of the offset
        push(12'hFFF, 14'h3FFF);
        chk("max_base", bus.out_addr, 32'hFFFFFFC0);
        burst("max", 32'hFFFFFFC0, 7);
        chk("max_last_addr", bus.out_addr, 32'hFFFFFFF8);
        @(negedge clk);
        chk("max_done", 32'(bus.count), 32'd0);

        // fill to DEPTH with the sink stalled
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(12'(i), 14'(16 * i));
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        push(12'h005, 14'h0050);
        chk("full_reject_count", 32'(bus.count), 32'd4);
        chk("full_head_beat", 32'(bus.out_beat), 32'd0);
        bus.out_ready = 1'b1;
        burst("drain0", mk(12'h001, 14'h0010), 7);
        chk("drain0_ready_lastbeat", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("drain_ready_after_pop", 32'(bus.in_ready), 32'd1);
        chk("drain_count_after_pop", 32'(bus.count), 32'd3);
        for (int i = 2; i <= 4; i++) burst("drain", mk(12'(i), 14'(16 * i)), 8);
        chk("drain_done", 32'(bus.count), 32'd0);

        // random stalls mid-burst
        push(12'h123, 14'h0456);
        eb = 0;
        for (int c = 0; c < 200 && eb < 8; c++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            chk("stall_addr", bus.out_addr, mk(12'h123, 14'h0456) + 32'(8 * eb));
            chk("stall_beat", 32'(bus.out_beat), 32'(eb));
            @(negedge clk);
            if (bus.out_ready) eb++;
        end
        chk("stall_beats_done", 32'(eb), 32'd8);
        chk("stall_count", 32'(bus.count), 32'd0);

        // push coinciding with last-beat pop at count=2
        bus.out_ready = 1'b0;
        push(12'h0A0, 14'h0001);
        push(12'h0B0, 14'h0002);
        chk("pp_count_pre", 32'(bus.count), 32'd2);
        bus.out_ready = 1'b1;
        burst("pp_a", mk(12'h0A0, 14'h0001), 7);
        chk("pp_a_last", 32'(bus.out_last), 32'd1);
        push(12'h0C0, 14'h0003);
        chk("pp_count_post", 32'(bus.count), 32'd2);
        burst("pp_b", mk(12'h0B0, 14'h0002), 8);
        burst("pp_c", mk(12'h0C0, 14'h0003), 8);
        chk("pp_done", 32'(bus.count), 32'd0);

        // asynchronous reset mid-burst
        bus.out_ready = 1'b0;
        push(12'h111, 14'h0011);
        push(12'h222, 14'h0022);
        push(12'h333, 14'h0033);
        bus.out_ready = 1'b1;
        burst("pre_rst", mk(12'h111, 14'h0011), 3);
        chk("pre_rst_beat", 32'(bus.out_beat), 32'd3);
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("post_rst");
        push(12'h444, 14'h0044);
        chk("post_rst_count", 32'(bus.count), 32'd1);
        burst("post_rst", mk(12'h444, 14'h0044), 8);
        chk("post_rst_done", 32'(bus.count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
